// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Brief    : Shared types, width helpers and select-width constants for rr_bus.
// Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

    // ceil(log2(value)); 0 for value <= 1
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Index width with a floor of one bit so single-port builds still elaborate
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        ERR_RESP  = 2'd2
    } bus_state_e;

    localparam int c_DEFAULT_NR_HOSTS   = 2;
    localparam int c_DEFAULT_NR_DEVICES = 2;
    localparam int c_HOST_SEL_W         = sel_width(c_DEFAULT_NR_HOSTS);
    localparam int c_DEVICE_SEL_W       = sel_width(c_DEFAULT_NR_DEVICES);

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin requester selection with an owned rotating pointer.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import bus_pkg::*;
#(
    parameter  int NrHosts = 2,
    localparam int c_SEL_W = sel_width(NrHosts)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NrHosts-1:0] i_req,
    input  logic               i_advance,
    output logic [c_SEL_W-1:0] o_sel,
    output logic               o_valid
);

    logic [c_SEL_W-1:0] r_ptr;
    logic [c_SEL_W-1:0] w_idx;

    // Scan from the farthest offset down so the nearest requester at/after the pointer wins
    always_comb begin
        o_sel   = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int i = NrHosts - 1; i >= 0; i--) begin
            w_idx = c_SEL_W'((int'(r_ptr) + i) % NrHosts);
            if (i_req[w_idx]) begin
                o_sel   = w_idx;
                o_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance && o_valid) begin
            r_ptr <= (o_sel == c_SEL_W'(NrHosts - 1)) ? '0 : o_sel + c_SEL_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_bus.sv
`default_nettype none
// ============================================================================
// Module   : rr_bus
// Brief    : Round-robin host-to-device interconnect, one outstanding transaction.
// Revision : 1.0 - initial release
// ============================================================================
module rr_bus
    import bus_pkg::*;
#(
    parameter  int NrHosts       = 2,
    parameter  int NrDevices     = 2,
    parameter  int DataWidth     = 32,
    parameter  int AddressWidth  = 32,
    parameter  int TimeoutCycles = 0,
    localparam int c_BE_W        = DataWidth / 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NrHosts-1:0]      host_req_i,
    output logic [NrHosts-1:0]      host_gnt_o,
    input  logic [AddressWidth-1:0] host_addr_i   [NrHosts],
    input  logic [NrHosts-1:0]      host_we_i,
    input  logic [c_BE_W-1:0]       host_be_i     [NrHosts],
    input  logic [DataWidth-1:0]    host_wdata_i  [NrHosts],
    output logic [NrHosts-1:0]      host_rvalid_o,
    output logic [NrHosts-1:0]      host_err_o,
    output logic [DataWidth-1:0]    host_rdata_o  [NrHosts],
    output logic [NrDevices-1:0]    device_req_o,
    input  logic [NrDevices-1:0]    device_gnt_i,
    output logic [AddressWidth-1:0] device_addr_o [NrDevices],
    output logic [NrDevices-1:0]    device_we_o,
    output logic [c_BE_W-1:0]       device_be_o   [NrDevices],
    output logic [DataWidth-1:0]    device_wdata_o[NrDevices],
    input  logic [NrDevices-1:0]    device_rvalid_i,
    input  logic [DataWidth-1:0]    device_rdata_i[NrDevices],
    input  logic [AddressWidth-1:0] cfg_device_addr_base[NrDevices],
    input  logic [AddressWidth-1:0] cfg_device_addr_mask[NrDevices]
);

    localparam int c_HOST_W  = sel_width(NrHosts);
    localparam int c_DEV_W   = sel_width(NrDevices);
    localparam int c_CNT_W   = sel_width(TimeoutCycles + 1);
    localparam int c_TO_LAST = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;

    bus_state_e          r_state;
    bus_state_e          w_state_next;
    logic [c_HOST_W-1:0] r_host_sel;
    logic [c_DEV_W-1:0]  r_dev_sel;
    logic [c_CNT_W-1:0]  r_cnt;

    logic [c_HOST_W-1:0] w_host_sel;
    logic                w_host_valid;
    logic                w_advance;
    logic [c_DEV_W-1:0]  w_dev_sel;
    logic                w_dev_hit;
    logic                w_timeout;

    rr_arbiter #(
        .NrHosts (NrHosts)
    ) u_arbiter (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_req     (host_req_i),
        .i_advance (w_advance),
        .o_sel     (w_host_sel),
        .o_valid   (w_host_valid)
    );

    // Descending scan leaves the lowest matching region as the winner
    always_comb begin
        w_dev_hit = 1'b0;
        w_dev_sel = '0;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((host_addr_i[w_host_sel] & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
                w_dev_hit = 1'b1;
                w_dev_sel = c_DEV_W'(d);
            end
        end
    end

    assign w_timeout = (TimeoutCycles > 0) && (r_cnt == c_CNT_W'(c_TO_LAST));

    always_comb begin
        w_state_next  = r_state;
        w_advance     = 1'b0;
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        device_req_o  = '0;
        device_we_o   = '0;
        for (int h = 0; h < NrHosts; h++) begin
            host_rdata_o[h] = '0;
        end
        for (int d = 0; d < NrDevices; d++) begin
            device_addr_o[d]  = '0;
            device_be_o[d]    = '0;
            device_wdata_o[d] = '0;
        end

        case (r_state)
            IDLE: begin
                if (w_host_valid) begin
                    if (w_dev_hit) begin
                        device_req_o[w_dev_sel]   = 1'b1;
                        device_addr_o[w_dev_sel]  = host_addr_i[w_host_sel];
                        device_we_o[w_dev_sel]    = host_we_i[w_host_sel];
                        device_be_o[w_dev_sel]    = host_be_i[w_host_sel];
                        device_wdata_o[w_dev_sel] = host_wdata_i[w_host_sel];
                        if (device_gnt_i[w_dev_sel]) begin
                            host_gnt_o[w_host_sel] = 1'b1;
                            w_advance              = 1'b1;
                            w_state_next           = WAIT_RESP;
                        end
                    end else begin
                        host_gnt_o[w_host_sel] = 1'b1;
                        w_advance              = 1'b1;
                        w_state_next           = ERR_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (device_rvalid_i[r_dev_sel]) begin
                    host_rvalid_o[r_host_sel] = 1'b1;
                    host_rdata_o[r_host_sel]  = device_rdata_i[r_dev_sel];
                    w_state_next              = IDLE;
                end else if (w_timeout) begin
                    host_rvalid_o[r_host_sel] = 1'b1;
                    host_err_o[r_host_sel]    = 1'b1;
                    w_state_next              = IDLE;
                end
            end
            ERR_RESP: begin
                host_rvalid_o[r_host_sel] = 1'b1;
                host_err_o[r_host_sel]    = 1'b1;
                w_state_next              = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_host_sel <= '0;
            r_dev_sel  <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_advance) begin
                r_host_sel <= w_host_sel;
                r_dev_sel  <= w_dev_sel;
            end
            // Counter only runs while a response is still pending
            if ((r_state == WAIT_RESP) && (w_state_next == WAIT_RESP)) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire
